// File: rtl/jtpopeye_bck_scroll.sv
// Scrolling low-resolution background layer: a cell bitmap scanned with per-line scroll/flip.
// CPU writes wait in a one-entry queue and use the clocks that video fetch leaves free.
module jtpopeye_bck_scroll #(
    parameter int unsigned CW  = 2,
    parameter int unsigned HCW = 6,
    parameter int unsigned VCW = 6,
    parameter int unsigned PW  = 1,
    parameter int unsigned DW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   cpu_we,
    input  logic [PW+VCW+HCW-1:0]  cpu_addr,
    input  logic [DW-1:0]          cpu_din,
    output logic                   cpu_busy,
    input  logic                   hs_load,
    input  logic [CW+HCW-1:0]      hscr,
    input  logic [CW+VCW+PW-1:0]   vscr,
    input  logic [CW+VCW+PW-1:0]   vpos,
    input  logic                   flip,
    input  logic                   enable,
    output logic [DW-1:0]          bakc
);

    localparam int unsigned HW    = CW + HCW;
    localparam int unsigned VW    = CW + VCW + PW;
    localparam int unsigned AW    = PW + VCW + HCW;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] Q_IDLE = 2'd0;
    localparam logic [1:0] Q_PEND = 2'd1;
    localparam logic [1:0] Q_DONE = 2'd2;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] row_l;
    logic [VW-1:0] row_sum;
    logic          flip_l;
    logic          rd_valid;
    logic [DW-1:0] vdata;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] vid_addr;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_din;
    logic [1:0]    q_state;
    logic [1:0]    q_state_nxt;
    logic          ram_we;
    logic          cell_last;

    logic [DW-1:0] mem [DEPTH];

    // Video fetch address and end-of-cell detect (direction follows the latched flip)
    always_comb begin
        vid_addr  = {row_l[VW-1 -: PW], row_l[CW+VCW-1:CW], h_cnt[HW-1:CW]};
        cell_last = flip_l ? (h_cnt[CW-1:0] == {CW{1'b0}})
                           : (h_cnt[CW-1:0] == {CW{1'b1}});
        row_sum   = vpos + vscr;
    end

    // Write queue: a captured write commits on the first clock without pxl_cen
    always_comb begin
        q_state_nxt = q_state;
        ram_we      = 1'b0;
        case (q_state)
            Q_IDLE: begin
                if (cpu_we) q_state_nxt = Q_PEND;
            end
            Q_PEND: begin
                if (!pxl_cen) begin
                    ram_we      = 1'b1;
                    q_state_nxt = Q_DONE;
                end
            end
            Q_DONE:  q_state_nxt = Q_IDLE;
            default: q_state_nxt = Q_IDLE;
        endcase
    end

    always_comb begin
        ram_addr = ram_we ? q_addr : vid_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_state  <= Q_IDLE;
            cpu_busy <= 1'b0;
            q_addr   <= '0;
            q_din    <= '0;
        end else begin
            q_state  <= q_state_nxt;
            cpu_busy <= (q_state_nxt != Q_IDLE);
            if (q_state == Q_IDLE && cpu_we) begin
                q_addr <= cpu_addr;
                q_din  <= cpu_din;
            end
        end
    end

    // Single-port RAM, one-clock read latency; contents are not reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= q_din;
        ram_q <= mem[ram_addr];
    end

    // Scan counters and output; vdata only samples the RAM right after a video read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            row_l    <= '0;
            flip_l   <= 1'b0;
            rd_valid <= 1'b0;
            vdata    <= '0;
            bakc     <= '0;
        end else begin
            rd_valid <= pxl_cen;
            if (rd_valid) vdata <= ram_q;
            if (pxl_cen) begin
                if (!enable)        bakc <= '0;
                else if (cell_last) bakc <= vdata;
                if (hs_load) begin
                    h_cnt  <= flip ? ~hscr : hscr;
                    row_l  <= flip ? ~row_sum : row_sum;
                    flip_l <= flip;
                end else begin
                    h_cnt <= flip_l ? h_cnt - HW'(1) : h_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_bck_scroll.sv
// Bench for jtpopeye_bck_scroll: hand-derived line vectors, CPU contention sequences,
// and randomized traffic checked every clock against a pixel-level reference model.
module tb_jtpopeye_bck_scroll;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pxl_cen = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [3:0]  cpu_din = '0;
    logic        cpu_busy;
    logic        hs_load = 1'b0;
    logic [7:0]  hscr = '0;
    logic [8:0]  vscr = '0;
    logic [8:0]  vpos = '0;
    logic        flip = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  bakc;

    jtpopeye_bck_scroll dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_busy (cpu_busy),
        .hs_load  (hs_load),
        .hscr     (hscr),
        .vscr     (vscr),
        .vpos     (vpos),
        .flip     (flip),
        .enable   (enable),
        .bakc     (bakc)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: pixel position, latched line setup, RAM image, queue
    logic [7:0]  m_h = '0;
    logic [8:0]  m_row = '0;
    logic        m_flip = 1'b0;
    logic [3:0]  m_last = '0;
    logic [3:0]  m_bakc = '0;
    logic        m_pend = 1'b0;
    logic        m_done = 1'b0;
    logic [12:0] m_qa = '0;
    logic [3:0]  m_qd = '0;
    logic [3:0]  mem_m [8192];

    typedef struct {
        logic [7:0] hscr;
        logic [8:0] vscr;
        logic [8:0] vpos;
        logic       flip;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] fill_val(input logic [12:0] a);
        logic [5:0] r;
        logic [5:0] c;
        r = a[11:6];
        c = a[5:0];
        if (!a[12]) return 4'(c + r);
        if (r == 6'd0 || r == 6'd63) return 4'hF;
        return 4'(c ^ r);
    endfunction

    // One clock: advance the model by the rules, then compare outputs
    task automatic step();
        logic [3:0] rd;
        @(posedge clk);
        if (!rst_n) begin
            m_h = '0; m_row = '0; m_flip = 1'b0; m_last = '0; m_bakc = '0;
            m_pend = 1'b0; m_done = 1'b0;
        end else begin
            if (m_done) m_done = 1'b0;
            else if (m_pend) begin
                if (!pxl_cen) begin
                    mem_m[m_qa] = m_qd;
                    m_pend = 1'b0;
                    m_done = 1'b1;
                end
            end else if (cpu_we) begin
                m_qa = cpu_addr;
                m_qd = cpu_din;
                m_pend = 1'b1;
            end
            if (pxl_cen) begin
                rd = mem_m[{m_row[8], m_row[7:2], m_h[7:2]}];
                if (!enable) m_bakc = '0;
                else if (m_flip ? (m_h[1:0] == 2'd0) : (m_h[1:0] == 2'd3)) m_bakc = m_last;
                m_last = rd;
                if (hs_load) begin
                    m_flip = flip;
                    m_h    = flip ? ~hscr : hscr;
                    m_row  = flip ? ~(vpos + vscr) : (vpos + vscr);
                end else begin
                    m_h = m_flip ? m_h - 8'd1 : m_h + 8'd1;
                end
            end
        end
        #1;
        check("bakc", int'(bakc), int'(m_bakc));
        check("busy", int'(cpu_busy), int'(m_pend | m_done));
    endtask

    task automatic cyc(input logic c);
        pxl_cen = c;
        step();
    endtask

    task automatic pix();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic line_start(input logic [7:0] h, input logic [8:0] vs,
                              input logic [8:0] vp, input logic f);
        if (pxl_cen) cyc(1'b0);
        hscr = h; vscr = vs; vpos = vp; flip = f;
        hs_load = 1'b1;
        cyc(1'b1);
        hs_load = 1'b0;
        cyc(1'b0);
    endtask

    task automatic fill_one(input logic [12:0] a, input logic [3:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        cyc(!pxl_cen);
        cpu_we = 1'b0;
        for (int k = 0; k < 8 && (m_pend | m_done); k++) cyc(!pxl_cen);
    endtask

    initial begin
        tbl[0]  = '{8'd0, 9'd0,   9'd0,   1'b0, 6,   4'd0};
        tbl[1]  = '{8'd0, 9'd0,   9'd0,   1'b0, 8,   4'd1};
        tbl[2]  = '{8'd0, 9'd0,   9'd0,   1'b0, 12,  4'd2};
        tbl[3]  = '{8'd0, 9'd0,   9'd0,   1'b0, 256, 4'd15};
        tbl[4]  = '{8'd0, 9'd0,   9'd0,   1'b0, 260, 4'd0};
        tbl[5]  = '{8'd9, 9'd0,   9'd0,   1'b0, 3,   4'd2};
        tbl[6]  = '{8'd9, 9'd0,   9'd0,   1'b0, 6,   4'd2};
        tbl[7]  = '{8'd9, 9'd0,   9'd0,   1'b0, 7,   4'd3};
        tbl[8]  = '{8'd0, 9'd4,   9'd0,   1'b0, 4,   4'd1};
        tbl[9]  = '{8'd0, 9'd4,   9'd0,   1'b0, 8,   4'd2};
        tbl[10] = '{8'd0, 9'd12,  9'd500, 1'b0, 8,   4'd1};
        tbl[11] = '{8'd0, 9'd56,  9'd200, 1'b0, 8,   4'd15};
        tbl[12] = '{8'd0, 9'd296, 9'd0,   1'b0, 8,   4'd11};
        tbl[13] = '{8'd0, 9'd0,   9'd511, 1'b1, 4,   4'd15};
        tbl[14] = '{8'd0, 9'd0,   9'd511, 1'b1, 8,   4'd14};
        tbl[15] = '{8'd0, 9'd0,   9'd0,   1'b1, 4,   4'd15};
        tbl[16] = '{8'd9, 9'd0,   9'd511, 1'b1, 3,   4'd13};
        tbl[17] = '{8'd9, 9'd0,   9'd511, 1'b1, 7,   4'd12};
        for (int i = 0; i < 8192; i++) mem_m[i] = '0;

        // Reset held with random activity
        #3 rst_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cpu_we = 1'($urandom); cpu_addr = 13'($urandom); cpu_din = 4'($urandom);
            hs_load = 1'($urandom); hscr = 8'($urandom); vscr = 9'($urandom);
            vpos = 9'($urandom); flip = 1'($urandom); enable = 1'($urandom);
            cyc(!pxl_cen);
        end
        cpu_we = 1'b0; hs_load = 1'b0; enable = 1'b0; flip = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cyc(!pxl_cen);
        check("reset_bakc", int'(bakc), 0);
        check("reset_busy", int'(cpu_busy), 0);

        // Fill the whole bitmap through the CPU port
        for (int a = 0; a < 8192; a++) fill_one(13'(a), fill_val(13'(a)));
        for (int i = 0; i < 4; i++) pix();
        enable = 1'b1;

        // Line vectors
        for (int i = 0; i < 18; i++) begin
            line_start(tbl[i].hscr, tbl[i].vscr, tbl[i].vpos, tbl[i].flip);
            for (int k = 0; k < tbl[i].n; k++) pix();
            check($sformatf("line%0d", i), int'(bakc), int'(tbl[i].exp));
        end

        // Write on a pxl_cen clock, second write during busy is dropped
        if (pxl_cen) cyc(1'b0);
        cpu_we = 1'b1; cpu_addr = 13'd6; cpu_din = 4'd9;
        cyc(1'b1);
        check("busyA0", int'(cpu_busy), 1);
        cpu_addr = 13'd5; cpu_din = 4'd12;
        cyc(1'b0);
        check("busyA1", int'(cpu_busy), 1);
        cpu_we = 1'b0;
        cyc(1'b1);
        check("busyA2", int'(cpu_busy), 0);
        cyc(1'b0);

        // Worst case: write on a non-cen clock, new write in the commit clock ignored
        cpu_we = 1'b1; cpu_addr = 13'd7; cpu_din = 4'd3;
        cyc(1'b0);
        check("busyB0", int'(cpu_busy), 1);
        cpu_we = 1'b0;
        cyc(1'b1);
        check("busyB1", int'(cpu_busy), 1);
        cpu_we = 1'b1; cpu_addr = 13'd8; cpu_din = 4'd0;
        cyc(1'b0);
        check("busyB2", int'(cpu_busy), 1);
        cpu_we = 1'b0;
        cyc(1'b1);
        check("busyB3", int'(cpu_busy), 0);
        cyc(1'b0);

        line_start(8'd0, 9'd0, 9'd0, 1'b0);
        for (int k = 0; k < 24; k++) pix();
        check("dropped_col5", int'(bakc), 5);
        for (int k = 0; k < 4; k++) pix();
        check("written_col6", int'(bakc), 9);
        for (int k = 0; k < 4; k++) pix();
        check("written_col7", int'(bakc), 3);
        for (int k = 0; k < 4; k++) pix();
        check("ignored_col8", int'(bakc), 8);

        // Enable toggle mid-line
        line_start(8'd0, 9'd0, 9'd0, 1'b0);
        for (int k = 0; k < 10; k++) pix();
        check("en_on", int'(bakc), 1);
        enable = 1'b0;
        pix();
        check("en_off11", int'(bakc), 0);
        pix();
        check("en_off12", int'(bakc), 0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) pix();
        check("en_hold15", int'(bakc), 0);
        pix();
        check("en_resume16", int'(bakc), 3);

        // Randomized traffic against the model
        begin
            int gap;
            logic c;
            gap = 0;
            for (int i = 0; i < 12000; i++) begin
                if (gap == 0) begin
                    c = 1'b1;
                    gap = int'($urandom_range(1, 2));
                end else begin
                    c = 1'b0;
                    gap--;
                end
                hs_load  = ($urandom_range(0, 40) == 0);
                hscr     = 8'($urandom);
                vscr     = 9'($urandom);
                vpos     = 9'($urandom);
                flip     = 1'($urandom);
                cpu_we   = ($urandom_range(0, 3) == 0);
                cpu_addr = 13'($urandom);
                cpu_din  = 4'($urandom);
                if ($urandom_range(0, 199) == 0) enable = !enable;
                cyc(c);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
